// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// XLEN and the reset vector live here so every fetch file agrees on them.
package fetch_queue_pkg;

    localparam int XLEN       = 32;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_ADDR_W = 10;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_VECTOR = 32'h0000_0000;

    // One FIFO slot: the PC the word was fetched from plus the fetched word.
    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    function automatic word_t align_pc(input word_t pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

    function automatic word_t next_pc(input word_t pc);
        return pc + word_t'(4);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the instruction-memory port, the redirect input and the
// downstream valid/ready channel of the fetch queue.
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    word_t             imem_rdata;

    logic              redirect;
    word_t             redirect_pc;

    logic              out_valid;
    logic              out_ready;
    word_t             out_pc;
    word_t             out_instr;
    word_t             out_pc_plus4;
    logic [CNT_W-1:0]  count;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output out_pc_plus4,
        output count
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  out_pc_plus4,
        input  count
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
// DEPTH must be a power of two so the pointers wrap for free.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    // Pop-and-push on a full FIFO is legal; the freed slot takes the new word.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign count     = cnt;

    push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch stage: owns the fetch PC, issues 1-cycle-latency reads and
// buffers returned words in fetch_fifo, flushing and refetching on redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int    DEPTH    = DEF_DEPTH,
    parameter int    ADDR_W   = DEF_ADDR_W,
    parameter word_t RESET_PC = RESET_VECTOR
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    word_t            fetch_pc;
    word_t            req_pc;
    logic             inflight;
    logic             issue;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   pending;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic [2*XLEN-1:0] head_bits;

    // Credit counts the word already on its way back, so a full FIFO can never be overrun.
    assign pending = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign issue   = !reset && !bus.redirect && (pending < (CNT_W+1)'(DEPTH));

    // A response returning during redirect or reset belongs to a dead fetch stream.
    assign push = inflight && !bus.redirect && !reset;
    assign pop  = bus.out_valid && bus.out_ready;

    assign push_entry = '{pc: req_pc, instr: bus.imem_rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
        end else if (bus.redirect) begin
            fetch_pc <= align_pc(bus.redirect_pc);
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= next_pc(fetch_pc);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect),
        .head_data (head_bits),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_entry = head_bits;

    assign bus.imem_req     = issue;
    assign bus.imem_addr    = fetch_pc[ADDR_W+1:2];
    assign bus.out_valid    = !fifo_empty;
    assign bus.out_pc       = head_entry.pc;
    assign bus.out_instr    = head_entry.instr;
    assign bus.out_pc_plus4 = next_pc(head_entry.pc);
    assign bus.count        = fifo_count;

    no_issue_when_full: assert property (@(posedge clk) disable iff (reset)
        fifo_full |-> !issue);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue with an epoch-tagged PC-stream scoreboard.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int    DEPTH  = 4;
    localparam int    ADDR_W = 10;
    localparam word_t RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          epoch;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          cur_epoch = 0;
    int          dut_epoch = 0;
    logic [31:0] gen_pc    = 32'h0;
    int          errors    = 0;
    int          checks    = 0;
    int          pops      = 0;
    int          n8        = 0;
    int          cyc       = 0;
    bit          use_nop   = 1'b1;

    function automatic logic [31:0] mem_word(input logic [9:0] a, input bit nop);
        return nop ? 32'h0000_0013 : {a, ~a, a, 2'b01};
    endfunction

    // Synchronous instruction memory; garbage on idle cycles exposes unqualified pushes.
    always @(posedge clk) begin
        if (bus.imem_req === 1'b1) bus.imem_rdata <= mem_word(bus.imem_addr, use_nop);
        else                       bus.imem_rdata <= $urandom;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic push_one();
        exp_t e;
        e.epoch = cur_epoch;
        e.pc    = gen_pc;
        e.instr = mem_word(gen_pc[11:2], use_nop);
        exp_q.push_back(e);
        gen_pc  = gen_pc + 32'd4;
    endtask

    // Every cycle with reset or redirect high starts a new expected PC stream.
    task automatic new_epoch(input logic [31:0] start);
        cur_epoch++;
        gen_pc = {start[31:2], 2'b00};
        repeat (24) push_one();
    endtask

    task automatic top_up();
        while (exp_q.size() < 24) push_one();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        top_up();
    endtask

    task automatic look();
        @(negedge clk);
        #3;
    endtask

    task automatic do_reset(input int n, input bit chk);
        for (int i = 0; i < n; i++) begin
            reset = 1'b1;
            new_epoch(RST_PC);
            if (chk && i == n - 1) begin
                look();
                check1("rst_out_valid", bus.out_valid, 1'b0);
                check32("rst_count", 32'(bus.count), 32'd0);
                check1("rst_imem_req", bus.imem_req, 1'b0);
            end
            step();
        end
        reset = 1'b0;
    endtask

    task automatic wait_count(input int target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            look();
            if (int'(bus.count) == target) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check1("wait_count_reached", found, 1'b1);
    endtask

    // Monitor: samples just before each active edge.
    always begin
        @(negedge clk);
        #4;
        if (reset === 1'b0) begin
            check1("count_bound", bus.count <= DEPTH, 1'b1);
            check1("valid_vs_count", bus.out_valid, bus.count != 0);
            if (bus.redirect === 1'b1) check1("req_on_redirect", bus.imem_req, 1'b0);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                while (exp_q.size() > 0 && exp_q[0].epoch < dut_epoch) void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: actual pc=%h required=no output", bus.out_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check32("out_pc", bus.out_pc, mon_e.pc);
                    check32("out_instr", bus.out_instr, mon_e.instr);
                    check32("out_pc_plus4", bus.out_pc_plus4, mon_e.pc + 32'd4);
                    pops++;
                    if (bus.out_pc == 32'h8) n8++;
                end
            end
        end
        if (reset === 1'b1 || bus.redirect === 1'b1) dut_epoch++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit found;
        int req_cyc;
        int pops_before;
        int r;

        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.out_ready   = 1'b0;
        step();

        // Startup latency and sequential stream
        bus.out_ready = 1'b1;
        do_reset(2, 1'b1);
        look();
        check1("t1_first_req", bus.imem_req, 1'b1);
        req_cyc = cyc;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            look();
            if (bus.out_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check1("t1_valid_seen", found, 1'b1);
        check32("t1_latency", 32'(cyc - req_cyc), 32'd2);
        repeat (10) step();

        // Back-pressure saturation, then in-order drain
        bus.out_ready = 1'b0;
        do_reset(2, 1'b0);
        repeat (10) step();
        look();
        check32("t2_count_full", 32'(bus.count), 32'd4);
        check1("t2_req_stalled", bus.imem_req, 1'b0);
        pops_before = pops;
        bus.out_ready = 1'b1;
        repeat (10) step();
        check1("t2_drained", (pops - pops_before) >= 4, 1'b1);

        // Redirect with three queued and one in flight
        bus.out_ready = 1'b0;
        do_reset(2, 1'b0);
        wait_count(3, found);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        new_epoch(32'h100);
        step();
        bus.redirect = 1'b0;
        look();
        check32("t3_count_flushed", 32'(bus.count), 32'd0);
        check1("t3_valid_flushed", bus.out_valid, 1'b0);
        check1("t3_refetch_req", bus.imem_req, 1'b1);
        bus.out_ready = 1'b1;
        repeat (8) step();

        // Redirect coinciding with a head pop
        bus.out_ready = 1'b0;
        do_reset(2, 1'b0);
        wait_count(4, found);
        step();
        bus.out_ready = 1'b1;
        n8 = 0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            look();
            if (bus.out_valid === 1'b1 && bus.out_pc == 32'h8) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check1("t4_head8_seen", found, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        new_epoch(32'h200);
        step();
        bus.redirect = 1'b0;
        look();
        check32("t4_count_flushed", 32'(bus.count), 32'd0);
        check1("t4_valid_flushed", bus.out_valid, 1'b0);
        repeat (6) step();
        check32("t4_pc8_once", 32'(n8), 32'd1);

        // One-cycle reset while loaded with a request in flight
        bus.out_ready = 1'b0;
        do_reset(2, 1'b0);
        wait_count(3, found);
        reset = 1'b1;
        new_epoch(RST_PC);
        #1;
        check1("t5_req_in_reset", bus.imem_req, 1'b0);
        step();
        reset = 1'b0;
        look();
        check32("t5_count", 32'(bus.count), 32'd0);
        check1("t5_valid", bus.out_valid, 1'b0);
        check1("t5_refetch_req", bus.imem_req, 1'b1);
        bus.out_ready = 1'b1;
        repeat (8) step();

        // Unaligned target and address wrap
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h103;
        new_epoch(32'h103);
        step();
        bus.redirect = 1'b0;
        repeat (8) step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        new_epoch(32'hFFFF_FFFC);
        step();
        bus.redirect = 1'b0;
        repeat (8) step();

        // Random traffic against hashed memory contents
        bus.out_ready = 1'b0;
        use_nop = 1'b0;
        do_reset(2, 1'b0);
        pops_before = pops;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (r < 2) begin
                reset           = 1'b1;
                bus.redirect    = 1'($urandom_range(0, 1));
                bus.redirect_pc = $urandom;
                new_epoch(RST_PC);
            end else if (r < 8) begin
                reset           = 1'b0;
                bus.redirect    = 1'b1;
                bus.redirect_pc = (r < 4) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
                new_epoch(bus.redirect_pc);
            end else begin
                reset        = 1'b0;
                bus.redirect = 1'b0;
            end
            step();
        end
        reset         = 1'b0;
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) step();
        check1("rand_progress", (pops - pops_before) > 300, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
